mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 158 +++++++++++++++
 tb/tb_mem_access.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access -- MEM-stage data-memory access controller.
//
// Turns the EX/MEM load/store request into a handshake with a data memory
// that can take a variable number of cycles (completion signalled by
// d_ready), and stalls the earlier pipeline stages for the duration.
//
// Ports
//   Clk, Reset                 clock, asynchronous active-high reset
//   EX_MEM_MemRead/MemWrite    load / store request (store wins if both set)
//   EX_MEM_ALUOut              effective address
//   EX_MEM_WriteData           store data
//   d_readM, d_writeM          data-memory strobes, high only while accessing
//   d_address, d_wdata         latched address / store data to the memory
//   d_rdata, d_ready           memory read data and completion acknowledge
//   MemData                    registered load result (to MEM/WB)
//   Mem_Stall                  freeze PC, IF/ID, ID/EX, EX/MEM
//   Mem_Error                  one-cycle pulse when an access is aborted
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has not
// completed within TIMEOUT_CYCLES cycles. Without it the controller waits
// indefinitely and Mem_Error is constant 0.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module mem_access #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  EX_MEM_MemRead,
  input  logic                  EX_MEM_MemWrite,
  input  logic [`WORD_SIZE-1:0] EX_MEM_ALUOut,
  input  logic [`WORD_SIZE-1:0] EX_MEM_WriteData,
  output logic                  d_readM,
  output logic                  d_writeM,
  output logic [`WORD_SIZE-1:0] d_address,
  output logic [`WORD_SIZE-1:0] d_wdata,
  input  logic [`WORD_SIZE-1:0] d_rdata,
  input  logic                  d_ready,
  output logic [`WORD_SIZE-1:0] MemData,
  output logic                  Mem_Stall,
  output logic                  Mem_Error
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_access: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  req;
  logic                  timeout_hit;
  logic [`WORD_SIZE-1:0] addr_p0;
  logic [`WORD_SIZE-1:0] wdata_p0;
  logic                  is_write_p0;

  assign req = EX_MEM_MemRead | EX_MEM_MemWrite;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and outputs. d_ready outside ACCESS has no effect because it
  // is only consulted in the ACCESS arm.
  always_comb begin
    state_nxt = state;
    Mem_Stall = 1'b0;
    d_readM   = 1'b0;
    d_writeM  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          Mem_Stall = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        Mem_Stall = 1'b1;
        d_readM   = ~is_write_p0;
        d_writeM  = is_write_p0;
        if (d_ready || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        // Stall drops here so the pipeline advances past this instruction
        // before the controller is back in IDLE; no re-issue.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture (p0) and load result
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_p0     <= '0;
      wdata_p0    <= '0;
      is_write_p0 <= 1'b0;
      MemData     <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_p0     <= EX_MEM_ALUOut;
        wdata_p0    <= EX_MEM_WriteData;
        // A store takes priority when both request bits are set.
        is_write_p0 <= EX_MEM_MemWrite;
      end
      if (state == ACCESS) begin
        // Completion beats a timeout landing on the same cycle.
        if (d_ready) begin
          if (!is_write_p0) MemData <= d_rdata;
        end else if (timeout_hit && !is_write_p0) begin
          MemData <= '1;
        end
      end
    end
  end

  assign d_address = addr_p0;
  assign d_wdata   = wdata_p0;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt;
  logic       err_q;

  // Counts ACCESS cycles without d_ready; the abort fires on the cycle the
  // count would reach TIMEOUT_CYCLES, i.e. after exactly that many cycles.
  assign timeout_hit = (state == ACCESS) && !d_ready && (to_cnt == TO_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      to_cnt <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && req)            to_cnt <= 8'd0;
      else if (state == ACCESS && !d_ready) to_cnt <= to_cnt + 8'd1;
      // Registered so the pulse lines up with the DONE cycle.
      err_q <= timeout_hit;
    end
  end

  assign Mem_Error = err_q;
`else
  assign timeout_hit = 1'b0;
  assign Mem_Error   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- scoreboard bench for mem_access.
// Stimulus pushes each expected memory transaction into a queue; a monitor
// pops it when the DUT completes a strobe with d_ready and checks the bus
// fields and the resulting MemData on the following (DONE) cycle.

module tb_mem_access;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        EX_MEM_MemRead = 1'b0;
  logic        EX_MEM_MemWrite = 1'b0;
  logic [15:0] EX_MEM_ALUOut = 16'h0;
  logic [15:0] EX_MEM_WriteData = 16'h0;
  logic        d_readM, d_writeM;
  logic [15:0] d_address, d_wdata;
  logic [15:0] d_rdata = 16'h0;
  logic        d_ready = 1'b0;
  logic [15:0] MemData;
  logic        Mem_Stall, Mem_Error;

  always #5 Clk = ~Clk;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .EX_MEM_ALUOut    (EX_MEM_ALUOut),
    .EX_MEM_WriteData (EX_MEM_WriteData),
    .d_readM          (d_readM),
    .d_writeM         (d_writeM),
    .d_address        (d_address),
    .d_wdata          (d_wdata),
    .d_rdata          (d_rdata),
    .d_ready          (d_ready),
    .MemData          (MemData),
    .Mem_Stall        (Mem_Stall),
    .Mem_Error        (Mem_Error)
  );

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void check1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check16(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor / scoreboard
  logic [15:0] model_md = 16'h0;
  logic        md_pend  = 1'b0;

  always @(negedge Clk) begin
    txn_t t;
    if (Reset) begin
      sb_q.delete();
      model_md = 16'h0;
      md_pend  = 1'b0;
    end else begin
      if (md_pend) begin
        check16("mon_memdata", MemData, model_md);
        md_pend = 1'b0;
      end
      if ((d_readM || d_writeM) && d_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mon_unexpected: access at %h, scoreboard empty", d_address);
        end else begin
          t = sb_q.pop_front();
          check1("mon_kind_wr", d_writeM, t.is_wr);
          check1("mon_kind_rd", d_readM, ~t.is_wr);
          check16("mon_addr", d_address, t.addr);
          if (t.is_wr) check16("mon_wdata", d_wdata, t.wdata);
          else         model_md = t.rdata;
          md_pend = 1'b1;
        end
      end
    end
  end

  // Called just after a rising edge with the controller in IDLE. Holds the
  // request while stalled (as a frozen EX/MEM would) and returns just after
  // the edge that ends DONE, with the request withdrawn.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int wait_cyc);
    txn_t t;
    EX_MEM_MemRead   = rd;
    EX_MEM_MemWrite  = wr;
    EX_MEM_ALUOut    = addr;
    EX_MEM_WriteData = wdata;
    t.is_wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    sb_q.push_back(t);
    @(negedge Clk);
    check1("idle_req_stall", Mem_Stall, 1'b1);
    check1("idle_req_strobe", d_readM | d_writeM, 1'b0);
    for (int k = 0; k < wait_cyc; k++) begin
      @(posedge Clk); #1;
      d_ready = (k == wait_cyc - 1);
      d_rdata = d_ready ? rdata : 16'hDEAD;
      @(negedge Clk);
      check1("acc_stall", Mem_Stall, 1'b1);
      check1("acc_wr", d_writeM, wr);
      check1("acc_rd", d_readM, ~wr);
      check16("acc_addr", d_address, addr);
      check16("acc_wdata", d_wdata, wdata);
    end
    @(posedge Clk); #1;
    d_ready = 1'b0;
    d_rdata = 16'h0;
    @(negedge Clk);
    check1("done_stall", Mem_Stall, 1'b0);
    check1("done_strobe", d_readM | d_writeM, 1'b0);
    check1("done_err", Mem_Error, 1'b0);
    @(posedge Clk); #1;
    EX_MEM_MemRead  = 1'b0;
    EX_MEM_MemWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 Reset = 1'b1;
    #2;
    check1("rst_stall", Mem_Stall, 1'b0);
    check1("rst_rd", d_readM, 1'b0);
    check1("rst_wr", d_writeM, 1'b0);
    check16("rst_memdata", MemData, 16'h0);
    check1("rst_err", Mem_Error, 1'b0);
    check16("rst_addr", d_address, 16'h0);
    check16("rst_wdata", d_wdata, 16'h0);
    @(posedge Clk); @(posedge Clk); #3;
    Reset = 1'b0;
    @(posedge Clk); #1;

    // d_ready while idle is ignored
    d_ready = 1'b1;
    d_rdata = 16'h5555;
    @(negedge Clk);
    check1("idle_rdy_stall", Mem_Stall, 1'b0);
    check1("idle_rdy_strobe", d_readM | d_writeM, 1'b0);
    @(posedge Clk); #1;
    d_ready = 1'b0;
    d_rdata = 16'h0;
    @(negedge Clk);
    check16("idle_rdy_memdata", MemData, 16'h0);
    @(posedge Clk); #1;

    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1);  // fast load
    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 3);  // slow store
    do_access(1'b1, 1'b0, 16'h0001, 16'h0000, 16'h1111, 1);  // back-to-back loads
    do_access(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222, 2);
    do_access(1'b1, 1'b1, 16'h0020, 16'hABCD, 16'h9999, 1);  // store wins
    do_access(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h4444, 4);  // ready on 4th cycle

    // Reset during the second ACCESS cycle of a load
    EX_MEM_MemRead = 1'b1;
    EX_MEM_ALUOut  = 16'h0050;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check1("rst_mid_pre_rd", d_readM, 1'b1);
    #2;
    Reset = 1'b1;
    EX_MEM_MemRead = 1'b0;
    #1;
    check1("rst_mid_rd", d_readM, 1'b0);
    check1("rst_mid_wr", d_writeM, 1'b0);
    check1("rst_mid_stall", Mem_Stall, 1'b0);
    check16("rst_mid_memdata", MemData, 16'h0);
    check16("rst_mid_addr", d_address, 16'h0);
    @(posedge Clk); #3;
    Reset = 1'b0;
    do_access(1'b1, 1'b0, 16'h0060, 16'h0000, 16'h7777, 1);  // first cycle after release

`ifdef MEM_TIMEOUT_EN
    EX_MEM_MemRead = 1'b1;
    EX_MEM_ALUOut  = 16'h0070;
    @(negedge Clk);
    check1("to_idle_stall", Mem_Stall, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      check1("to_acc_stall", Mem_Stall, 1'b1);
      check1("to_acc_rd", d_readM, 1'b1);
      check1("to_acc_err", Mem_Error, 1'b0);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    check1("to_done_stall", Mem_Stall, 1'b0);
    check1("to_done_rd", d_readM, 1'b0);
    check16("to_done_memdata", MemData, 16'hFFFF);
    check1("to_done_err", Mem_Error, 1'b1);
    @(posedge Clk); #1;
    EX_MEM_MemRead = 1'b0;
    @(negedge Clk);
    check1("to_after_err", Mem_Error, 1'b0);
    check1("to_after_stall", Mem_Stall, 1'b0);
`else
    EX_MEM_MemRead = 1'b1;
    EX_MEM_ALUOut  = 16'h0070;
    @(negedge Clk);
    check1("hang_idle_stall", Mem_Stall, 1'b1);
    for (int k = 0; k < 25; k++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      check1("hang_stall", Mem_Stall, 1'b1);
      check1("hang_rd", d_readM, 1'b1);
      check1("hang_err", Mem_Error, 1'b0);
    end
    #1;
    Reset = 1'b1;
    EX_MEM_MemRead = 1'b0;
    #1;
    check1("hang_rst_stall", Mem_Stall, 1'b0);
    check1("hang_rst_rd", d_readM, 1'b0);
    @(posedge Clk); #3;
    Reset = 1'b0;
`endif

    @(posedge Clk); #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d transactions outstanding, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
